mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage ARM pipeline. It sits directly downstream of the execute stage and consumes its outputs: write-back enable, memory read/write enables, ALU result (used as address), Rm value (store data) and destination register. It holds the instruction in its EXE/MEM register and performs a multi-cycle access to an internal word-addressed data memory. While the access is in progress it stalls the upstream pipeline. It registers the results into the MEM/WB outputs for the write-back stage.

## Interface
- BASE_ADDR, 1024: byte address mapped to memory word 0
- DEPTH, 64: number of 32-bit words in data memory
- WAIT_CYCLES, 2: extra busy cycles per memory access, legal range 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_en_in  in  1  write-back enable from execute
- mem_r_en_in  in  1  load request from execute
- mem_w_en_in  in  1  store request from execute
- alu_result_in  in  32  ALU result / byte address from execute
- val_rm_in  in  32  store data from execute
- dest_in  in  4  destination register from execute
- mem_stall  out  1  combinational; high freezes PC, IF/ID, ID/EXE and execute inputs
- wb_en_out  out  1  registered write-back enable to WB
- mem_r_en_out  out  1  registered; selects mem_data_out over alu_result_out in WB
- alu_result_out  out  32  registered ALU result
- mem_data_out  out  32  registered load data
- dest_out  out  4  registered destination
- addr_err  out  1  registered one-cycle pulse on an out-of-range access

## Operation
- EXE/MEM register R holds wb_en, mem_r_en, mem_w_en, alu_result, val_rm and dest. R loads the *_in values on every rising edge where mem_stall=0 and holds them otherwise.
- mem_op = R.mem_r_en | R.mem_w_en.
- Address decode:
  - idx = (R.alu_result − BASE_ADDR) >> 2, a 32-bit unsigned subtract; bits [1:0] are ignored.
  - in_range = (R.alu_result ≥ BASE_ADDR) && (idx < DEPTH).
- FSM states are IDLE, BUSY and DONE, with a counter cnt of 4 bits.
  - IDLE, mem_op=1: go to BUSY, cnt ← WAIT_CYCLES−1.
  - IDLE, mem_op=0: stay in IDLE.
  - BUSY, cnt≠0: cnt ← cnt−1.
  - BUSY, cnt=0: go to DONE. On this same edge the access happens:
    - store, in range: mem[idx] ← R.val_rm;
    - load, in range: rdata ← mem[idx];
    - out of range: no write, rdata ← 0, addr_err pulses for one cycle.
  - DONE: go to IDLE unconditionally.
- mem_stall = mem_op && (state ≠ DONE). Non-memory instructions never stall.
- If both R.mem_r_en and R.mem_w_en are set, the store is performed and rdata ← 0.
- MEM/WB outputs are updated on each edge:
  - mem_stall=0: load R's wb_en, mem_r_en, alu_result and dest. mem_data_out ← rdata if R.mem_r_en, else 0.
  - mem_stall=1: load a bubble. wb_en_out=0, mem_r_en_out=0, all other outputs 0.
- Data memory is not reset. Contents persist across rst.

## Timing
- Reset (rst=0, asynchronous):
  - R cleared; state IDLE; cnt 0; rdata 0.
  - All registered outputs are 0, so mem_stall=0.
  - Reset asserted before the BUSY→DONE edge: no write occurs and the access is abandoned.
- Non-memory instruction: 1 cycle in R, with latency 1 from EXE outputs to MEM/WB outputs.
- Memory instruction:
  - Stays in R for WAIT_CYCLES+2 cycles.
  - mem_stall is high for WAIT_CYCLES+1 consecutive cycles (IDLE plus BUSY) and low in DONE.
  - Its MEM/WB outputs appear on the edge ending DONE.
  - WB sees exactly one valid copy, preceded by WAIT_CYCLES+1 bubbles.
- Upstream contract: *_in are stable while mem_stall=1. Values sampled are those present on the edge where mem_stall=0.
- Back-to-back memory ops: the second enters R on the edge ending the first's DONE and begins in IDLE the next cycle. There are no idle gaps beyond the stall.
- A store followed by a load of the same address returns the stored value, because the write completes before the load enters R.
- addr_err is high exactly in the DONE cycle of a faulting access.

## Test plan
- Reset: rst=0 mid-BUSY of a store to 1024 with value 0xDEADBEEF, then rst=1 and a load from 1024 → all outputs 0 during reset, and the load does not return 0xDEADBEEF.
- ALU pass-through: wb_en=1, alu_result=0x55, dest=3, no mem op → one edge later wb_en_out=1, alu_result_out=0x55, dest_out=3, mem_stall never high.
- Store then load, WAIT_CYCLES=2: store 0x12345678 to address 1028, then load 1028 into dest 5 → mem_stall high 3 cycles per op; load yields mem_data_out=0x12345678, mem_r_en_out=1, dest_out=5 once, with bubbles before it.
- Boundaries: load from 1020 and from 1024+4·64=1280 → addr_err pulses, mem_data_out=0, memory unchanged. Store/load at 1276 (last word) → succeeds.
- Stall freeze: change *_in while mem_stall=1 → the value captured is the one present when mem_stall falls; no duplicate wb_en_out.
- WAIT_CYCLES=1 back-to-back loads → each stalls exactly 2 cycles, results in order.

Source files
------------

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory stage of the five-stage ARM pipeline. Holds the current
//             instruction in the EXE/MEM register, performs a multi-cycle
//             access to a word-addressed internal data memory, stalls the
//             upstream pipeline while the access is in flight, and registers
//             results into the MEM/WB outputs.
//  Ports    : clk            - rising-edge clock
//             rst            - asynchronous active-low reset
//             wb_en_in       - write-back enable from execute
//             mem_r_en_in    - load request from execute
//             mem_w_en_in    - store request from execute
//             alu_result_in  - ALU result / byte address from execute
//             val_rm_in      - store data from execute
//             dest_in        - destination register from execute
//             mem_stall      - combinational upstream freeze
//             wb_en_out      - registered write-back enable
//             mem_r_en_out   - registered load flag (WB mux select)
//             alu_result_out - registered ALU result
//             mem_data_out   - registered load data
//             dest_out       - registered destination register
//             addr_err       - one-cycle pulse on an out-of-range access
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int BASE_ADDR   = 1024,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] val_rm_in,
   input  logic [3:0]  dest_in,
   output logic        mem_stall,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data_out,
   output logic [3:0]  dest_out,
   output logic        addr_err
);

   localparam int          c_addr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] c_base      = 32'(BASE_ADDR);
   localparam logic [31:0] c_depth     = 32'(DEPTH);
   localparam logic [3:0]  c_wait_init = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // EXE/MEM register
   logic        r_wb_en;
   logic        r_mem_r_en;
   logic        r_mem_w_en;
   logic [31:0] r_alu_result;
   logic [31:0] r_val_rm;
   logic [3:0]  r_dest;

   // Access sequencing
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_rdata;
   logic        r_addr_err;

   // MEM/WB register
   logic        r_wb_en_out;
   logic        r_mem_r_en_out;
   logic [31:0] r_alu_result_out;
   logic [31:0] r_mem_data_out;
   logic [3:0]  r_dest_out;

   // Data memory, deliberately without reset so contents survive rst
   logic [31:0] r_mem [0:DEPTH-1];

   logic                w_mem_op;
   logic [31:0]         w_offset;
   logic                w_in_range;
   logic [c_addr_w-1:0] w_idx;
   logic                w_access;
   logic                w_unused;

   assign w_mem_op = r_mem_r_en | r_mem_w_en;

   // Unsigned subtract: addresses below the base wrap to a huge offset, but
   // the explicit >= test rejects them regardless.
   assign w_offset   = r_alu_result - c_base;
   assign w_in_range = (r_alu_result >= c_base) && ({2'b00, w_offset[31:2]} < c_depth);
   assign w_idx      = w_offset[c_addr_w+1:2];
   assign w_unused   = &{1'b0, w_offset[1:0]};

   // The access itself happens on the BUSY->DONE edge
   assign w_access  = (r_state == ST_BUSY) && (r_cnt == 4'd0);
   assign mem_stall = w_mem_op && (r_state != ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_en          <= 1'b0;
         r_mem_r_en       <= 1'b0;
         r_mem_w_en       <= 1'b0;
         r_alu_result     <= '0;
         r_val_rm         <= '0;
         r_dest           <= '0;
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_rdata          <= '0;
         r_addr_err       <= 1'b0;
         r_wb_en_out      <= 1'b0;
         r_mem_r_en_out   <= 1'b0;
         r_alu_result_out <= '0;
         r_mem_data_out   <= '0;
         r_dest_out       <= '0;
      end else begin
         if (!mem_stall) begin
            r_wb_en      <= wb_en_in;
            r_mem_r_en   <= mem_r_en_in;
            r_mem_w_en   <= mem_w_en_in;
            r_alu_result <= alu_result_in;
            r_val_rm     <= val_rm_in;
            r_dest       <= dest_in;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_mem_op) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= c_wait_init;
               end
            end
            ST_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         // A combined load+store performs only the store and reads back zero
         if (w_access) begin
            r_rdata <= (w_in_range && r_mem_r_en && !r_mem_w_en) ? r_mem[w_idx] : '0;
         end
         r_addr_err <= w_access && !w_in_range;

         if (!mem_stall) begin
            r_wb_en_out      <= r_wb_en;
            r_mem_r_en_out   <= r_mem_r_en;
            r_alu_result_out <= r_alu_result;
            r_mem_data_out   <= r_mem_r_en ? r_rdata : '0;
            r_dest_out       <= r_dest;
         end else begin
            r_wb_en_out      <= 1'b0;
            r_mem_r_en_out   <= 1'b0;
            r_alu_result_out <= '0;
            r_mem_data_out   <= '0;
            r_dest_out       <= '0;
         end
      end
   end

   // Gated by rst so a store is abandoned if reset is held on its access edge
   always_ff @(posedge clk) begin
      if (rst && w_access && r_mem_w_en && w_in_range) begin
         r_mem[w_idx] <= r_val_rm;
      end
   end

   assign wb_en_out      = r_wb_en_out;
   assign mem_r_en_out   = r_mem_r_en_out;
   assign alu_result_out = r_alu_result_out;
   assign mem_data_out   = r_mem_data_out;
   assign dest_out       = r_dest_out;
   assign addr_err       = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. Two instances (WAIT_CYCLES=2
//             and WAIT_CYCLES=1) run the same style of instruction stream in
//             parallel against an instruction-level reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam int          c_base  = 1024;
   localparam int          c_depth = 64;
   localparam logic [31:0] c_lim   = 32'(c_base + 4 * c_depth);

   typedef struct packed {
      logic        wb;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  dest;
   } instr_t;

   typedef struct packed {
      logic        wb;
      logic        rd;
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [3:0]  dest;
   } res_t;

   logic        clk;
   logic        rst_v   [2];
   logic        wb_i    [2];
   logic        rd_i    [2];
   logic        wr_i    [2];
   logic [31:0] alu_i   [2];
   logic [31:0] rm_i    [2];
   logic [3:0]  dest_i  [2];
   logic        stall_o [2];
   logic        wb_o    [2];
   logic        rd_o    [2];
   logic [31:0] alu_o   [2];
   logic [31:0] md_o    [2];
   logic [3:0]  dest_o  [2];
   logic        ae_o    [2];

   logic [31:0] mmem [2][c_depth];
   res_t        prev [2];

   int n_checks = 0;
   int n_errors = 0;

   mem_stage #(.BASE_ADDR(c_base), .DEPTH(c_depth), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst_v[0]),
      .wb_en_in(wb_i[0]), .mem_r_en_in(rd_i[0]), .mem_w_en_in(wr_i[0]),
      .alu_result_in(alu_i[0]), .val_rm_in(rm_i[0]), .dest_in(dest_i[0]),
      .mem_stall(stall_o[0]), .wb_en_out(wb_o[0]), .mem_r_en_out(rd_o[0]),
      .alu_result_out(alu_o[0]), .mem_data_out(md_o[0]), .dest_out(dest_o[0]),
      .addr_err(ae_o[0])
   );

   mem_stage #(.BASE_ADDR(c_base), .DEPTH(c_depth), .WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .rst(rst_v[1]),
      .wb_en_in(wb_i[1]), .mem_r_en_in(rd_i[1]), .mem_w_en_in(wr_i[1]),
      .alu_result_in(alu_i[1]), .val_rm_in(rm_i[1]), .dest_in(dest_i[1]),
      .mem_stall(stall_o[1]), .wb_en_out(wb_o[1]), .mem_r_en_out(rd_o[1]),
      .alu_result_out(alu_o[1]), .mem_data_out(md_o[1]), .dest_out(dest_o[1]),
      .addr_err(ae_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_out(input int k, input res_t e, input logic st, input logic ae);
      check_val($sformatf("d%0d mem_stall", k),      32'(stall_o[k]), 32'(st));
      check_val($sformatf("d%0d addr_err", k),       32'(ae_o[k]),    32'(ae));
      check_val($sformatf("d%0d wb_en_out", k),      32'(wb_o[k]),    32'(e.wb));
      check_val($sformatf("d%0d mem_r_en_out", k),   32'(rd_o[k]),    32'(e.rd));
      check_val($sformatf("d%0d alu_result_out", k), alu_o[k],        e.alu);
      check_val($sformatf("d%0d mem_data_out", k),   md_o[k],         e.mdata);
      check_val($sformatf("d%0d dest_out", k),       32'(dest_o[k]),  32'(e.dest));
   endtask

   task automatic drive(input int k, input instr_t t);
      wb_i[k]   = t.wb;
      rd_i[k]   = t.rd;
      wr_i[k]   = t.wr;
      alu_i[k]  = t.addr;
      rm_i[k]   = t.data;
      dest_i[k] = t.dest;
   endtask

   // Garbage on the inputs during a stall must never be captured
   task automatic drive_junk(input int k);
      wb_i[k]   = 1'($urandom);
      rd_i[k]   = 1'($urandom);
      wr_i[k]   = 1'($urandom);
      alu_i[k]  = $urandom;
      rm_i[k]   = $urandom;
      dest_i[k] = 4'($urandom);
   endtask

   function automatic instr_t mk(input logic wb, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] dest);
      instr_t t;
      t.wb = wb; t.rd = rd; t.wr = wr; t.addr = addr; t.data = data; t.dest = dest;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int     kind;
      int     sel;
      t      = '0;
      t.wb   = 1'($urandom);
      t.data = $urandom;
      t.dest = 4'($urandom);
      kind   = int'($urandom_range(0, 5));
      case (kind)
         2: begin t.rd = 1'b1; t.wb = 1'b1; end
         3: t.wr = 1'b1;
         4: begin t.rd = 1'b1; t.wr = 1'b1; end
         default: ;
      endcase
      sel = int'($urandom_range(0, 11));
      if (sel == 0)      t.addr = 32'(c_base) - 32'(4 * $urandom_range(1, 3));
      else if (sel == 1) t.addr = c_lim + 32'($urandom_range(0, 15));
      else if (sel == 2) t.addr = $urandom;
      else               t.addr = 32'(c_base) + 32'(4 * $urandom_range(0, c_depth - 1))
                                  + 32'($urandom_range(0, 3));
      return t;
   endfunction

   // Execute one instruction. Entry: negedge of its first cycle in EXE/MEM.
   // A memory op occupies WAIT+2 cycles, stalling in all but the last; the
   // first cycle still shows the previous instruction's result, later cycles
   // show bubbles. The next instruction is presented in the last cycle.
   task automatic run(input int k, input int w, input instr_t cur, input instr_t nxt);
      res_t r;
      logic mem_op;
      logic ok;
      int   idx;
      int   len;
      res_t z;
      z      = '0;
      mem_op = cur.rd | cur.wr;
      ok     = (cur.addr >= 32'(c_base)) && (cur.addr < c_lim);
      idx    = ok ? int'((cur.addr - 32'(c_base)) / 4) : 0;
      r.wb    = cur.wb;
      r.rd    = cur.rd;
      r.alu   = cur.addr;
      r.dest  = cur.dest;
      r.mdata = '0;
      if (cur.rd && !cur.wr && ok) r.mdata = mmem[k][idx];
      if (cur.wr && ok) mmem[k][idx] = cur.data;
      len = mem_op ? w + 2 : 1;
      for (int c = 1; c <= len; c++) begin
         check_out(k, (c == 1) ? prev[k] : z, c < len, (c == len) && mem_op && !ok);
         if (c == len) drive(k, nxt);
         else          drive_junk(k);
         @(negedge clk);
      end
      prev[k] = r;
   endtask

   task automatic run_queue(input int k, input int w, input instr_t q[$], input instr_t last_nxt);
      for (int i = 0; i < q.size(); i++) begin
         run(k, w, q[i], (i + 1 < q.size()) ? q[i + 1] : last_nxt);
      end
   endtask

   task automatic run_all(input int k, input int w);
      instr_t q[$];
      instr_t nop;
      instr_t db_store;
      res_t   z;
      nop      = '0;
      z        = '0;
      db_store = mk(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd0);

      rst_v[k] = 1'b0;
      drive(k, nop);
      repeat (2) @(negedge clk);
      check_out(k, z, 1'b0, 1'b0);

      // Preload every word so the model knows the whole memory
      for (int i = 0; i < c_depth; i++) begin
         q.push_back(mk(1'b0, 1'b0, 1'b1, 32'(c_base + 4 * i),
                        (i == 0) ? 32'h11111111 : $urandom, 4'd0));
      end
      rst_v[k] = 1'b1;
      prev[k]  = z;
      drive(k, q[0]);
      @(negedge clk);
      run_queue(k, w, q, db_store);

      // Abandon the 0xDEADBEEF store with a reset while it is busy
      check_out(k, prev[k], 1'b1, 1'b0);
      drive_junk(k);
      @(negedge clk);
      check_out(k, z, 1'b1, 1'b0);
      rst_v[k] = 1'b0;
      #1;
      check_out(k, z, 1'b0, 1'b0);
      @(negedge clk);
      check_out(k, z, 1'b0, 1'b0);

      q.delete();
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1));         // must be 0x11111111
      q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3));           // ALU pass-through
      q.push_back(mk(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 4'd0));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd6));         // below range
      q.push_back(mk(1'b1, 1'b1, 1'b0, c_lim, 32'h0, 4'd7));            // past end
      q.push_back(mk(1'b0, 1'b0, 1'b1, c_lim, 32'hBAD0BAD0, 4'd0));     // faulting store
      q.push_back(mk(1'b0, 1'b0, 1'b1, c_lim - 32'd4, 32'hA5A55A5A, 4'd0));
      q.push_back(mk(1'b1, 1'b1, 1'b0, c_lim - 32'd4, 32'h0, 4'd8));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9));         // back-to-back loads
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd10));
      q.push_back(mk(1'b1, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 4'd11)); // load+store
      q.push_back(mk(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd12));
      for (int i = 0; i < 80; i++) q.push_back(rand_instr());

      rst_v[k] = 1'b1;
      prev[k]  = z;
      drive(k, q[0]);
      @(negedge clk);
      run_queue(k, w, q, nop);
      check_out(k, prev[k], 1'b0, 1'b0);
   endtask

   initial begin
      fork
         run_all(0, 2);
         run_all(1, 1);
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
